// File: rtl/cpu_mem_bus_pkg.sv
// Shared types for the core <-> memory bus arbiter.
//   arb_state_e : arbiter FSM states
//   MEM_ID_*    : id tags carried on the memory bus
//   mem_req_t   : one latched memory request (the grant register)
package cpu_mem_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RELEASE
  } arb_state_e;

  localparam logic MEM_ID_DCACHE = 1'b0;
  localparam logic MEM_ID_ICACHE = 1'b1;

  typedef struct packed {
    logic              read;
    logic              write;
    logic              id;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/cpu_mem_bus_arbiter.sv
// Registered two-master arbiter between the dcache/icache miss ports and the
// memory bus. One miss is granted at a time and held until memory answers;
// the response is routed back by id. dcache has priority unless the icache
// has waited STARVE_LIMIT consecutive dcache grants.
// Ports:
//   clock, reset                 core clock, async active-high reset
//   d_req_* / i_req_*            level requests from dcache / icache
//   d_resp_valid, i_resp_valid   one-cycle response pulses
//   resp_addr, resp_data         shared response payload
//   i_bus_avail                  no dcache request pending or granted
//   mem_read/write/id/addr/data  one-cycle memory request strobe
//   mem_resp_*                   memory response (reads and write acks)
// ADDR_WIDTH / LINE_WIDTH must not exceed the package widths.
module cpu_mem_bus_arbiter
  import cpu_mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LINE_WIDTH   = 128,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  d_req_read,
  input  logic                  d_req_write,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [LINE_WIDTH-1:0] d_req_data,
  input  logic                  i_req_read,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [LINE_WIDTH-1:0] i_req_data,
  output logic                  d_resp_valid,
  output logic                  i_resp_valid,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [LINE_WIDTH-1:0] resp_data,
  output logic                  i_bus_avail,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_id,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_data,
  input  logic                  mem_resp_valid,
  input  logic                  mem_resp_id,
  input  logic [ADDR_WIDTH-1:0] mem_resp_addr,
  input  logic [LINE_WIDTH-1:0] mem_resp_data
);

  localparam int unsigned       CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state, state_next;
  mem_req_t         grant, grant_next;
  logic [CNT_W-1:0] starve_cnt, starve_next;

  logic d_any, i_any, pick_i, resp_hit;

  assign d_any    = d_req_read | d_req_write;
  assign i_any    = i_req_read | i_req_write;
  assign pick_i   = i_any & (~d_any | (starve_cnt == CNT_MAX));
  assign resp_hit = mem_resp_valid & (mem_resp_id == grant.id);

  assign mem_id      = grant.id;
  assign mem_addr    = grant.addr[ADDR_WIDTH-1:0];
  assign mem_data    = grant.data[LINE_WIDTH-1:0];
  assign i_bus_avail = ~d_any & ~((grant.id == MEM_ID_DCACHE) & (state != ARB_IDLE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      starve_cnt <= starve_next;
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    starve_next  = starve_cnt;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    d_resp_valid = 1'b0;
    i_resp_valid = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (d_any | i_any) begin
          // write wins when a master raises read and write together
          if (pick_i) begin
            grant_next.id    = MEM_ID_ICACHE;
            grant_next.write = i_req_write;
            grant_next.read  = i_req_read & ~i_req_write;
            grant_next.addr  = ADDR_W'(i_req_addr);
            grant_next.data  = LINE_W'(i_req_data);
          end else begin
            grant_next.id    = MEM_ID_DCACHE;
            grant_next.write = d_req_write;
            grant_next.read  = d_req_read & ~d_req_write;
            grant_next.addr  = ADDR_W'(d_req_addr);
            grant_next.data  = LINE_W'(d_req_data);
          end
          if (!pick_i && i_any)
            starve_next = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
          else
            starve_next = '0;
          state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_read   = grant.read;
        mem_write  = grant.write;
        // memory may answer in the strobe cycle itself
        state_next = resp_hit ? ARB_RELEASE : ARB_WAIT;
      end
      ARB_WAIT: begin
        if (resp_hit) state_next = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        d_resp_valid = (grant.id == MEM_ID_DCACHE);
        i_resp_valid = (grant.id == MEM_ID_ICACHE);
        state_next   = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_addr <= '0;
      resp_data <= '0;
    end else if (resp_hit && (state == ARB_ISSUE || state == ARB_WAIT)) begin
      resp_addr <= mem_resp_addr;
      resp_data <= mem_resp_data;
    end
  end

endmodule
